cordic_seq_ctrl: RTL and testbench
==================================

Name: cordic_seq_ctrl

Overview:
Sequencer for the 8-bit CORDIC datapath. It accepts one operation per start/done handshake in either rotation mode (theta in) or vectoring mode (x, y in). It drives the datapath input-mux, counter-reset and counter-hold controls for exactly NUM_ITER micro-rotations, then holds the result until the requester acknowledges. It also cross-checks the datapath's iteration counter and raises a sticky error on mismatch.

Parameters:
NUM_ITER, 8, micro-rotations per operation; legal range 1..15.
CW, 4, width of the datapath iteration counter and of the internal iteration count.

Ports:
clka  input  1  sole clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; accepted when ready=1
mode_in  input  1  operation mode sampled with an accepted start; 0=rotation, 1=vectoring
ack  input  1  requester has consumed the result; meaningful only while done=1
abort  input  1  cancel the operation in progress
counter  input  CW  iteration counter reported back by the datapath
ready  output  1  controller idle; start will be accepted
busy  output  1  operation in progress (LOAD or ITER)
done  output  1  result valid on the datapath outputs
cordic_mode  output  1  latched mode driven to the datapath
in_mux_ctl  output  2  00=load theta with x/y cleared, 01=feedback, 10=load x/y, 11=hold
counter_rst  output  1  clear the datapath iteration counter
counter_hold  output  1  freeze the datapath iteration counter
seq_err  output  1  sticky counter-mismatch flag

Behaviour:
- Moore FSM with states IDLE, LOAD, ITER, DONE. All outputs are decoded from registered state, cordic_mode and seq_err only; no input reaches an output combinationally.
- Reset (async, any time, including mid-operation) forces: state=IDLE, iter_cnt=0, cordic_mode=0, seq_err=0, ready=1, busy=0, done=0, in_mux_ctl=11, counter_rst=1, counter_hold=0.
- IDLE: ready=1, in_mux_ctl=11, counter_rst=1. If start=1, latch cordic_mode<=mode_in and go to LOAD.
- LOAD (exactly 1 cycle): busy=1, counter_rst=1, iter_cnt<=0. in_mux_ctl=00 when cordic_mode=0, 10 when cordic_mode=1. Next state is ITER.
- ITER: busy=1, in_mux_ctl=01, counter_rst=0, counter_hold=0. iter_cnt increments each cycle.
  - When iter_cnt==NUM_ITER-1, go to DONE. ITER therefore lasts exactly NUM_ITER cycles.
  - Every ITER cycle, if counter!=iter_cnt, set seq_err<=1. seq_err clears only on reset.
- DONE: done=1, in_mux_ctl=11, counter_hold=1, counter_rst=0. Datapath outputs stay stable.
  - Remain in DONE until ack=1.
  - ack=1 and start=0: go to IDLE.
  - ack=1 and start=1: latch mode_in and go directly to LOAD (back-to-back op, no IDLE cycle).
- Latency: start accepted at edge k; LOAD during cycle k+1; ITER during cycles k+2..k+NUM_ITER+1; done=1 from cycle k+NUM_ITER+2.
- start while busy or done (without ack): ignored, not queued. mode_in is ignored outside acceptance.
- ack outside DONE: ignored.
- abort=1 in LOAD, ITER or DONE: next state is IDLE, done never asserts for that operation, seq_err is unchanged. abort in IDLE: no effect, and an accompanying start is suppressed (abort wins over start in every state).
- cordic_mode is constant from LOAD through DONE.
- iter_cnt is CW bits and never wraps, because NUM_ITER<=2^CW-1.

Test Plan:
- Rotation op, NUM_ITER=8: start=1 with mode_in=0 at edge 0, counter model tracks the expected sequence -> in_mux_ctl=00 in cycle 1; 01 for cycles 2..9; done=1 with in_mux_ctl=11 and counter_hold=1 from cycle 10 until ack; back to IDLE one cycle after ack; seq_err=0.
- Vectoring op: mode_in=1 -> in_mux_ctl=10 in LOAD and cordic_mode=1 throughout; done delayed 5 cycles by late ack -> outputs stable, state stays DONE.
- Back-to-back: ack=1 and start=1 (mode_in=0) together in DONE -> LOAD on the next cycle with in_mux_ctl=00; ready never asserts between operations.
- Abort at 3rd ITER cycle -> IDLE next cycle, done stays 0, counter_rst=1; a fresh start then completes normally.
- Counter mismatch: model holds counter=2 for two consecutive ITER cycles -> seq_err=1 and stays 1 across later operations until rst.
- Async reset pulse mid-ITER between clock edges -> immediately state IDLE, busy=0, in_mux_ctl=11, counter_rst=1, seq_err=0.

Source files
------------

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the 8-bit CORDIC datapath: drives input mux and counter controls for
// NUM_ITER micro-rotations per start/done handshake and cross-checks the datapath counter.
module cordic_seq_ctrl #(
  parameter int NUM_ITER = 8,
  parameter int CW       = 4
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          start,
  input  logic          mode_in,
  input  logic          ack,
  input  logic          abort,
  input  logic [CW-1:0] counter,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          cordic_mode,
  output logic [1:0]    in_mux_ctl,
  output logic          counter_rst,
  output logic          counter_hold,
  output logic          seq_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] ITER_LAST = CW'(NUM_ITER - 1);
  localparam logic [CW-1:0] ITER_ONE  = CW'(1);
  localparam logic [CW-1:0] ITER_ZERO = CW'(0);

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;

  // State, iteration count, latched mode and sticky error registers
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= ITER_ZERO;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; abort takes priority over every other request
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d  = mode_in;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        iter_d = ITER_ZERO;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        iter_d = iter_q + ITER_ONE;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // An aborted cycle leaves the error flag untouched
          if (counter != iter_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (iter_q == ITER_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ack && start) begin
          mode_d  = mode_in;
          state_d = S_LOAD;
        end else if (ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state only
  always_comb begin
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    in_mux_ctl   = 2'b11;
    counter_rst  = 1'b0;
    counter_hold = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready       = 1'b1;
        counter_rst = 1'b1;
      end
      S_LOAD: begin
        busy        = 1'b1;
        counter_rst = 1'b1;
        in_mux_ctl  = mode_q ? 2'b10 : 2'b00;
      end
      S_ITER: begin
        busy       = 1'b1;
        in_mux_ctl = 2'b01;
      end
      S_DONE: begin
        done         = 1'b1;
        counter_hold = 1'b1;
      end
      default: begin
        ready       = 1'b1;
        counter_rst = 1'b1;
      end
    endcase
  end

  assign cordic_mode = mode_q;
  assign seq_err     = err_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Randomized self-checking bench for cordic_seq_ctrl against a cycle-age reference model.
module tb_cordic_seq_ctrl;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clka = 1'b0;
  logic          rst;
  logic          start, mode_in, ack, abort;
  logic [CW-1:0] counter;
  logic          ready, busy, done, cordic_mode, counter_rst, counter_hold, seq_err;
  logic [1:0]    in_mux_ctl;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_age is cycles since the accepting edge (-1 = idle).
  // age 0 = load, ages 1..N = iterations, age N+1 = result held.
  int m_age  = -1;
  bit m_mode = 1'b0;
  bit m_err  = 1'b0;
  int cnt_ovr = -1;
  bit corrupt_en = 1'b0;

  cordic_seq_ctrl #(.NUM_ITER(N), .CW(CW)) dut (
    .clka(clka), .rst(rst), .start(start), .mode_in(mode_in), .ack(ack),
    .abort(abort), .counter(counter), .ready(ready), .busy(busy), .done(done),
    .cordic_mode(cordic_mode), .in_mux_ctl(in_mux_ctl), .counter_rst(counter_rst),
    .counter_hold(counter_hold), .seq_err(seq_err)
  );

  always #5 clka = ~clka;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t age=%0d)", tag, obs, exp, $time, m_age);
    end
  endtask

  task automatic check_outputs();
    int em;
    if (m_age < 0)        em = 3;
    else if (m_age == 0)  em = m_mode ? 2 : 0;
    else if (m_age <= N)  em = 1;
    else                  em = 3;
    check_val("ready",        32'(ready),        32'(m_age < 0));
    check_val("busy",         32'(busy),         32'(m_age >= 0 && m_age <= N));
    check_val("done",         32'(done),         32'(m_age == N + 1));
    check_val("in_mux_ctl",   32'(in_mux_ctl),   32'(em));
    check_val("counter_rst",  32'(counter_rst),  32'(m_age <= 0));
    check_val("counter_hold", 32'(counter_hold), 32'(m_age == N + 1));
    check_val("cordic_mode",  32'(cordic_mode),  32'(m_mode));
    check_val("seq_err",      32'(seq_err),      32'(m_err));
  endtask

  task automatic step(input bit st, input bit md, input bit ak, input bit ab);
    int na;
    bit nm, ne;
    start = st; mode_in = md; ack = ak; abort = ab;
    if (m_age >= 1 && m_age <= N) begin
      if (cnt_ovr >= 0)                                  counter = CW'(cnt_ovr);
      else if (corrupt_en && $urandom_range(0, 39) == 0) counter = CW'(m_age);
      else                                               counter = CW'(m_age - 1);
    end else begin
      counter = CW'($urandom);
    end
    na = m_age; nm = m_mode; ne = m_err;
    if (m_age < 0) begin
      if (st && !ab) begin na = 0; nm = md; end
    end else if (ab) begin
      na = -1;
    end else if (m_age <= N) begin
      if (m_age >= 1 && int'(counter) != m_age - 1) ne = 1'b1;
      na = m_age + 1;
    end else if (ak) begin
      if (st) begin na = 0; nm = md; end
      else na = -1;
    end
    @(posedge clka);
    #1;
    m_age = na; m_mode = nm; m_err = ne;
    check_outputs();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    m_age = -1; m_mode = 1'b0; m_err = 1'b0;
    check_outputs();
    @(posedge clka);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode_in = 1'b0; ack = 1'b0; abort = 1'b0; counter = '0;
    #1;
    check_outputs();
    @(posedge clka);
    #1;
    check_outputs();
    rst = 1'b0;

    // Rotation op
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rot_load_mux", 32'(in_mux_ctl), 32'd0);
    idle_cycles(N);
    check_val("rot_busy_last", 32'(busy), 32'd1);
    idle_cycles(1);
    check_val("rot_done", 32'(done), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("rot_idle", 32'(ready), 32'd1);

    // Vectoring op with late ack
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("vec_load_mux", 32'(in_mux_ctl), 32'd2);
    idle_cycles(N + 1 + 5);
    check_val("vec_done_held", 32'(done), 32'd1);
    check_val("vec_mode", 32'(cordic_mode), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(N + 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("b2b_load_mux", 32'(in_mux_ctl), 32'd0);
    check_val("b2b_ready", 32'(ready), 32'd0);
    idle_cycles(N + 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Abort at third iteration, then a fresh op
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("abort_ready", 32'(ready), 32'd1);
    check_val("abort_cnt_rst", 32'(counter_rst), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("abort_idle_start", 32'(ready), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(N + 1);
    check_val("after_abort_done", 32'(done), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Counter held at 2 for two iteration cycles
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3);
    cnt_ovr = 2;
    idle_cycles(2);
    cnt_ovr = -1;
    check_val("mismatch_err", 32'(seq_err), 32'd1);
    idle_cycles(N);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(N + 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("err_sticky", 32'(seq_err), 32'd1);

    // Async reset mid-iteration
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(3);
    async_reset();
    check_val("rst_err_clear", 32'(seq_err), 32'd0);

    // Randomized traffic
    corrupt_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
             $urandom_range(0, 24) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
